// File: rtl/eth_axis_packet_gen_pkg.sv
// eth_axis_pkt_gen_pkg: shared types and helpers for the AXI4-Stream packet generator.
//   mode_e          payload mode (counter / fixed / PRBS31; reserved encoding behaves as fixed)
//   state_e         generator FSM states
//   PRBS31_SEED     LFSR value after reset
//   keep_from_rem() tkeep mask from (length mod keep width); remainder 0 means a full beat
package eth_axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_FIXED   = 2'd1,
        MODE_PRBS    = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

    // Upper bound on tkeep width (DATA_WIDTH up to 1024); callers slice the low bits.
    localparam int KEEP_MAX = 128;

    function automatic logic [KEEP_MAX-1:0] keep_from_rem(input int unsigned rem,
                                                         input int unsigned kw);
        keep_from_rem = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < kw && (rem == 0 || i < rem)) keep_from_rem[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/eth_axis_packet_gen_if.sv
// eth_axis_packet_gen_if: AXI4-Stream data channel between the packet generator and its sink.
//   tdata/tkeep/tvalid/tlast : master -> slave
//   tready                   : slave -> master
interface eth_axis_packet_gen_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_axis_packet_gen_prbs31.sv
// prbs31_gen: PRBS31 (x^31 + x^28 + 1) word source.
//   clk, rst_n : clock, async active-low reset (state returns to PRBS31_SEED)
//   advance    : consume the current word; state steps WIDTH bits
//   word       : next WIDTH sequence bits, first generated bit in bit 0
// The word is a pure function of the held state, so it stays stable until advance.
module prbs31_gen
    import eth_axis_pkt_gen_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [WIDTH-1:0] word
);
    logic [30:0] lfsr;
    logic [30:0] lfsr_nxt;

    always_comb begin
        lfsr_nxt = lfsr;
        word     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word[i]  = lfsr_nxt[30] ^ lfsr_nxt[27];
            lfsr_nxt = {lfsr_nxt[29:0], word[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lfsr <= PRBS31_SEED;
        else if (advance) lfsr <= lfsr_nxt;
    end
endmodule

// File: rtl/eth_axis_packet_gen.sv
// eth_axis_packet_gen: AXI4-Stream test-packet source (counter / fixed / PRBS31 payload).
//   m00_axis_aclk, m00_axis_aresetn : clock, async active-low reset
//   enable                          : level run request
//   cfg_mode/len_bytes/gap_cycles/pkt_count/pattern : per-packet configuration,
//                                     captured when a packet's first beat is entered
//   m00_axis                        : AXIS master (eth_axis_packet_gen_if.master)
//   busy, done, pkts_sent           : run status
// Optional: define ETH_AXIS_PKT_GEN_STATS_EN to add stat_bytes / stat_stall_cycles.
module eth_axis_packet_gen
    import eth_axis_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_aresetn,
    input  logic                  enable,
    input  logic [1:0]            cfg_mode,
    input  logic [LEN_WIDTH-1:0]  cfg_len_bytes,
    input  logic [GAP_WIDTH-1:0]  cfg_gap_cycles,
    input  logic [31:0]           cfg_pkt_count,
    input  logic [DATA_WIDTH-1:0] cfg_pattern,
    eth_axis_packet_gen_if.master m00_axis,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pkts_sent
`ifdef ETH_AXIS_PKT_GEN_STATS_EN
    ,
    output logic [47:0]           stat_bytes,
    output logic [31:0]           stat_stall_cycles
`endif
);
    state_e                state, state_d;
    mode_e                 mode_q;
    logic [LEN_WIDTH-1:0]  bytes_left;
    logic [GAP_WIDTH-1:0]  gap_q, gap_cnt;
    logic [31:0]           count_q, pkts_q, pkts_inc;
    logic [DATA_WIDTH-1:0] pattern_q, cnt_word, prbs_word;
    logic [15:0]           beat_idx;
    logic [KEEP_MAX-1:0]   keep_full;
    logic                  tvalid, accept, is_last, pkt_end, final_pkt;
    logic                  start_pkt, start_run;

    assign tvalid    = (state == DATA);
    assign accept    = tvalid & m00_axis.tready;
    assign is_last   = (bytes_left <= LEN_WIDTH'(KEEP_WIDTH));
    assign pkt_end   = accept & is_last;
    assign pkts_inc  = (pkts_q == '1) ? pkts_q : pkts_q + 32'd1;
    assign final_pkt = (count_q != 32'd0) && (pkts_inc == count_q);

    always_comb begin
        state_d   = state;
        start_pkt = 1'b0;
        start_run = 1'b0;
        case (state)
            IDLE: if (enable) begin
                state_d   = DATA;
                start_pkt = 1'b1;
                start_run = 1'b1;
            end
            DATA: if (pkt_end) begin
                if (final_pkt)           state_d = DONE;
                else if (!enable)        state_d = IDLE;
                else if (gap_q != '0)    state_d = GAP;
                else begin
                    state_d   = DATA;
                    start_pkt = 1'b1;
                end
            end
            GAP: if (gap_cnt <= GAP_WIDTH'(1)) begin
                state_d   = DATA;
                start_pkt = 1'b1;
            end
            DONE: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state      <= IDLE;
            mode_q     <= MODE_COUNTER;
            bytes_left <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            count_q    <= '0;
            pattern_q  <= '0;
            beat_idx   <= '0;
            pkts_q     <= '0;
        end else begin
            state <= state_d;
            // A new packet's load wins over the accept of the previous last beat.
            if (start_pkt) begin
                mode_q     <= mode_e'(cfg_mode);
                bytes_left <= (cfg_len_bytes == '0) ? LEN_WIDTH'(1) : cfg_len_bytes;
                gap_q      <= cfg_gap_cycles;
                count_q    <= cfg_pkt_count;
                pattern_q  <= cfg_pattern;
                beat_idx   <= '0;
            end else if (accept) begin
                bytes_left <= bytes_left - LEN_WIDTH'(KEEP_WIDTH);
                beat_idx   <= beat_idx + 16'd1;
            end
            if (pkt_end)            gap_cnt <= gap_q;
            else if (state == GAP)  gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            if (start_run)          pkts_q  <= '0;
            else if (pkt_end)       pkts_q  <= pkts_inc;
        end
    end

    // PRBS only moves on beats that actually carried PRBS payload.
    prbs31_gen #(.WIDTH(DATA_WIDTH)) u_prbs (
        .clk     (m00_axis_aclk),
        .rst_n   (m00_axis_aresetn),
        .advance (accept && mode_q == MODE_PRBS),
        .word    (prbs_word)
    );

    generate
        if (DATA_WIDTH > 32) begin : g_cnt_wide
            assign cnt_word = {pattern_q[DATA_WIDTH-1:32], pkts_q[15:0], beat_idx};
        end else begin : g_cnt_narrow
            assign cnt_word = {pkts_q[15:0], beat_idx};
        end
    endgenerate

    // On the last beat bytes_left is 1..KEEP_WIDTH; a full beat maps to remainder 0.
    assign keep_full = keep_from_rem((is_last && bytes_left != LEN_WIDTH'(KEEP_WIDTH))
                                     ? 32'(bytes_left) : 32'd0, 32'(KEEP_WIDTH));

    always_comb begin
        m00_axis.tvalid = tvalid;
        m00_axis.tlast  = tvalid & is_last;
        m00_axis.tkeep  = tvalid ? keep_full[KEEP_WIDTH-1:0] : '0;
        m00_axis.tdata  = '0;
        if (tvalid) begin
            case (mode_q)
                MODE_COUNTER: m00_axis.tdata = cnt_word;
                MODE_PRBS:    m00_axis.tdata = prbs_word;
                default:      m00_axis.tdata = pattern_q;
            endcase
        end
    end

    assign busy      = (state == DATA) || (state == GAP);
    assign done      = (state == DONE);
    assign pkts_sent = pkts_q;

`ifdef ETH_AXIS_PKT_GEN_STATS_EN
    logic [48:0] bytes_sum;
    assign bytes_sum = {1'b0, stat_bytes}
                     + 49'(is_last ? 32'(bytes_left) : 32'(KEEP_WIDTH));

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            stat_bytes        <= '0;
            stat_stall_cycles <= '0;
        end else if (start_run) begin
            stat_bytes        <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (accept)
                stat_bytes <= bytes_sum[48] ? '1 : bytes_sum[47:0];
            if (tvalid && !m00_axis.tready && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_eth_axis_packet_gen.sv
module tb_eth_axis_packet_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_len = 16'd0;
    logic [7:0]  cfg_gap = 8'd0;
    logic [31:0] cfg_count = 32'd0;
    logic [63:0] cfg_pattern = 64'd0;
    logic        busy, done;
    logic [31:0] pkts_sent;
`ifdef ETH_AXIS_PKT_GEN_STATS_EN
    logic [47:0] stat_bytes;
    logic [31:0] stat_stall_cycles;
`endif

    eth_axis_packet_gen_if #(.DATA_WIDTH(64)) axis ();

    eth_axis_packet_gen #(.DATA_WIDTH(64)) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .enable           (enable),
        .cfg_mode         (cfg_mode),
        .cfg_len_bytes    (cfg_len),
        .cfg_gap_cycles   (cfg_gap),
        .cfg_pkt_count    (cfg_count),
        .cfg_pattern      (cfg_pattern),
        .m00_axis         (axis),
        .busy             (busy),
        .done             (done),
        .pkts_sent        (pkts_sent)
`ifdef ETH_AXIS_PKT_GEN_STATS_EN
        ,
        .stat_bytes        (stat_bytes),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          tests = 0, fails = 0;
    int          beats_acc = 0, stalls = 0, gap_cnt = 0, last_gap = -1;
    bit          in_gap = 0, rand_ready = 0, prev_stall = 0;
    beat_t       prev_beat;
    logic [30:0] tb_prbs = 31'h7FFF_FFFF;

    // tready changes just after each rising edge; everything is observed on the falling edge.
    always @(posedge clk) begin
        #1;
        axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        beat_t cur, e;
        cur = '{axis.tdata, axis.tkeep, axis.tlast};
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                tests++;
                assert (axis.tvalid === 1'b1 && cur === prev_beat) else begin
                    fails++;
                    $error("FAIL stall_hold: got v=%0b %h expected v=1 %h", axis.tvalid, cur, prev_beat);
                end
            end
            if (in_gap) begin
                if (!axis.tvalid) gap_cnt++;
                else begin last_gap = gap_cnt; in_gap = 0; end
            end
            if (axis.tvalid && axis.tready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL extra_beat: got %h expected no beat", cur);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    tests++;
                    assert (cur === e) else begin
                        fails++;
                        $error("FAIL beat: got %h/%h/%b expected %h/%h/%b",
                               cur.data, cur.keep, cur.last, e.data, e.keep, e.last);
                    end
                end
                beats_acc++;
                if (axis.tlast) begin in_gap = 1; gap_cnt = 0; end
            end
            prev_stall = axis.tvalid && !axis.tready;
            if (prev_stall) begin stalls++; prev_beat = cur; end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prbs_next(output logic [63:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            b       = tb_prbs[30] ^ tb_prbs[27];
            w[i]    = b;
            tb_prbs = {tb_prbs[29:0], b};
        end
    endtask

    // Reference model: expected beats for n packets of one configuration.
    task automatic push_pkts(input int mode, input int n, input int len, input logic [63:0] pat);
        int    eff, nb, rem;
        beat_t bt;
        eff = (len == 0) ? 1 : len;
        nb  = (eff + 7) / 8;
        rem = eff % 8;
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < nb; b++) begin
                bt.last = (b == nb - 1);
                bt.keep = (bt.last && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
                case (mode)
                    0:       bt.data = {pat[63:32], 16'(p), 16'(b)};
                    2:       prbs_next(bt.data);
                    default: bt.data = pat;
                endcase
                exp_q.push_back(bt);
            end
        end
    endtask

    task automatic cfg(input int mode, input int len, input int gap, input int cnt,
                       input logic [63:0] pat);
        cfg_mode = 2'(mode); cfg_len = 16'(len); cfg_gap = 8'(gap);
        cfg_count = 32'(cnt); cfg_pattern = pat;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin step(1); c++; end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic wait_beats(input int k, input int budget);
        int c = 0;
        while (beats_acc < k && c < budget) begin step(1); c++; end
        chk("beats_reached", 64'(beats_acc >= k), 64'd1);
    endtask

    task automatic finish_run();
        enable = 1'b0;
        step(2);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        in_gap = 0;
        rand_ready = 0;
    endtask

    initial begin
        axis.tready = 1'b1;
        // Reset state
        step(3);
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tdata", axis.tdata, 64'd0);
        chk("rst_tkeep", 64'(axis.tkeep), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pkts", 64'(pkts_sent), 64'd0);
        rst_n = 1'b1;
        step(2);

        // 1: counter mode, 20 bytes, back-to-back, 3 packets
        cfg(0, 20, 0, 3, 64'h1234_5678_0000_0000);
        push_pkts(0, 3, 20, cfg_pattern);
        enable = 1'b1;
        wait_done(200);
        chk("t1_pkts", 64'(pkts_sent), 64'd3);
        chk("t1_queue", 64'(exp_q.size()), 64'd0);
        chk("t1_gap", 64'(last_gap), 64'd0);
        finish_run();

        // 2: 64 bytes (full last beat), gap 5
        cfg(0, 64, 5, 2, 64'h0);
        push_pkts(0, 2, 64, cfg_pattern);
        enable = 1'b1;
        wait_done(300);
        chk("t2_gap", 64'(last_gap), 64'd5);
        chk("t2_pkts", 64'(pkts_sent), 64'd2);
        chk("t2_queue", 64'(exp_q.size()), 64'd0);
        finish_run();

        // 3: random backpressure, 37-byte packets
        cfg(0, 37, 2, 4, 64'hCAFE_F00D_0000_0000);
        push_pkts(0, 4, 37, cfg_pattern);
        stalls = 0;
        rand_ready = 1;
        enable = 1'b1;
        wait_done(1000);
        chk("t3_pkts", 64'(pkts_sent), 64'd4);
        chk("t3_queue", 64'(exp_q.size()), 64'd0);
        chk("t3_gap", 64'(last_gap), 64'd2);
`ifdef ETH_AXIS_PKT_GEN_STATS_EN
        chk("t3_stalls", 64'(stat_stall_cycles), 64'(stalls));
        chk("t3_bytes", 64'(stat_bytes), 64'd148);
`endif
        finish_run();

        // 4: enable dropped mid-packet in continuous mode -> packet completes, then idle
        cfg(0, 64, 0, 0, 64'h0);
        push_pkts(0, 1, 64, cfg_pattern);
        beats_acc = 0;
        enable = 1'b1;
        wait_beats(2, 50);
        enable = 1'b0;
        begin
            int c = 0;
            while (busy !== 1'b0 && c < 50) begin step(1); c++; end
        end
        step(2);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_tvalid", 64'(axis.tvalid), 64'd0);
        chk("t4_pkts", 64'(pkts_sent), 64'd1);
        chk("t4_queue", 64'(exp_q.size()), 64'd0);
        in_gap = 0;

        // 5: reset mid-packet, then a fresh run
        cfg(0, 16, 0, 0, 64'h0);
        push_pkts(0, 4, 16, cfg_pattern);
        beats_acc = 0;
        enable = 1'b1;
        wait_beats(5, 50);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("t5_rst_pkts", 64'(pkts_sent), 64'd0);
        exp_q.delete();
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        in_gap = 0;
        step(1);
        cfg(0, 16, 0, 1, 64'h0);
        push_pkts(0, 1, 16, cfg_pattern);
        enable = 1'b1;
        wait_done(100);
        chk("t5_pkts", 64'(pkts_sent), 64'd1);
        chk("t5_queue", 64'(exp_q.size()), 64'd0);
        finish_run();

        // 6: zero length treated as one byte, fixed pattern
        cfg(1, 0, 1, 3, 64'hDEAD_BEEF_0123_4567);
        push_pkts(1, 3, 0, cfg_pattern);
        enable = 1'b1;
        wait_done(100);
        chk("t6_pkts", 64'(pkts_sent), 64'd3);
        chk("t6_queue", 64'(exp_q.size()), 64'd0);
        chk("t6_gap", 64'(last_gap), 64'd1);
        finish_run();

        // 7: PRBS31 under backpressure (LFSR at seed since the reset in step 5)
        cfg(2, 16, 0, 3, 64'h0);
        push_pkts(2, 3, 16, cfg_pattern);
        rand_ready = 1;
        enable = 1'b1;
        wait_done(300);
        chk("t7_queue", 64'(exp_q.size()), 64'd0);
        chk("t7_pkts", 64'(pkts_sent), 64'd3);
        finish_run();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
